// File: rtl/operand_sequencer.sv
// Operand-pair sequencer: walks a burst of table addresses, presenting one
// registered (op_a, op_b) pair per fetch and holding it until accepted downstream.
module operand_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              abort,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [CNT_W-1:0]   remaining_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic [DATA_W-1:0]  op_a_nxt;
  logic [DATA_W-1:0]  op_b_nxt;
  logic               op_valid_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  // State, datapath and registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      pc        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      pc        <= pc_nxt;
      op_a      <= op_a_nxt;
      op_b      <= op_b_nxt;
      op_valid  <= op_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-output logic; abort outside IDLE overrides everything
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    pc_nxt        = pc;
    op_a_nxt      = op_a;
    op_b_nxt      = op_b;

    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            if (count != '0) begin
              pc_nxt        = start_addr;
              remaining_nxt = count;
              state_nxt     = S_FETCH;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
        S_FETCH: begin
          op_a_nxt  = a_in;
          op_b_nxt  = b_in;
          state_nxt = S_HOLD;
        end
        S_HOLD: begin
          if (op_ready) begin
            if (remaining > CNT_W'(1)) begin
              remaining_nxt = remaining - CNT_W'(1);
              pc_nxt        = pc + ADDR_W'(1);
              state_nxt     = S_FETCH;
            end else begin
              state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    op_valid_nxt = (state_nxt == S_HOLD);
    busy_nxt     = (state_nxt == S_FETCH) || (state_nxt == S_HOLD);
    done_nxt     = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: transaction-level reference model with
// per-cycle output compare, directed scenarios and a randomized soak.
module tb_operand_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   count;
  logic              abort;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_valid;
  logic              op_ready;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] tbl_a [DEPTH];
  logic [DATA_W-1:0] tbl_b [DEPTH];

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;

  operand_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .count(count), .abort(abort), .pc(pc), .a_in(a_in), .b_in(b_in),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign a_in = tbl_a[pc];
  assign b_in = tbl_b[pc];

  // Reference model: a burst is a list of addresses (sa + k) mod DEPTH, k < n;
  // each pair is fetched, then held until accepted.
  int                m_sa, m_n, m_k;
  bit                m_busy, m_fetch, m_valid, m_done;
  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_a, m_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0;
      m_pc = '0; m_a = '0; m_b = '0; m_k = 0; m_n = 0; m_sa = 0;
    end else if (abort && (m_busy || m_done)) begin
      m_busy = 0; m_fetch = 0; m_valid = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_fetch) begin
      m_a = tbl_a[m_pc];
      m_b = tbl_b[m_pc];
      m_fetch = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (op_ready) begin
        m_valid = 0;
        if (m_k + 1 < m_n) begin
          m_k = m_k + 1;
          m_pc = ADDR_W'((m_sa + m_k) % DEPTH);
          m_fetch = 1;
        end else begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end else if (start && !abort) begin
      if (count == 0) begin
        m_done = 1;
      end else begin
        m_sa = int'(start_addr);
        m_n  = int'(count);
        m_k  = 0;
        m_pc = start_addr;
        m_busy = 1;
        m_fetch = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (pc !== m_pc || op_valid !== m_valid || busy !== m_busy || done !== m_done ||
          (m_valid && (op_a !== m_a || op_b !== m_b))) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got pc=%h v=%b a=%h b=%h busy=%b done=%b exp pc=%h v=%b a=%h b=%h busy=%b done=%b",
                 $time, pc, op_valid, op_a, op_b, busy, done,
                 m_pc, m_valid, m_a, m_b, m_busy, m_done);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic go(input int sa, input int n);
    start = 1'b1;
    start_addr = ADDR_W'(sa);
    count = (ADDR_W + 1)'(n);
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    start = 1'b0;
    abort = 1'b0;
    op_ready = 1'b1;
    for (int i = 0; i < 64 && (m_busy || m_done); i++) step();
    lit("drain_idle", 32'(busy | done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0;
    abort = 1'b0; op_ready = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tbl_a[i] = DATA_W'($urandom);
      tbl_b[i] = DATA_W'($urandom);
    end
    tbl_a[0] = 16'h000A; tbl_b[0] = 16'h0005;
    tbl_a[1] = 16'h0010; tbl_b[1] = 16'h0008;
    tbl_a[2] = 16'h00FF; tbl_b[2] = 16'h000F;
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    lit("rst_pc", 32'(pc), 32'd0);
    lit("rst_op_a", 32'(op_a), 32'd0);
    lit("rst_flags", 32'({op_valid, busy, done}), 32'd0);

    // Three pairs back to back
    op_ready = 1'b1;
    go(0, 3);
    step();
    lit("b3_p0_a", 32'(op_a), 32'h000A);
    lit("b3_p0_b", 32'(op_b), 32'h0005);
    lit("b3_p0_v", 32'(op_valid), 32'd1);
    step(); step();
    lit("b3_p1_a", 32'(op_a), 32'h0010);
    step(); step();
    lit("b3_p2_a", 32'(op_a), 32'h00FF);
    lit("b3_p2_b", 32'(op_b), 32'h000F);
    step();
    lit("b3_done", 32'(done), 32'd1);
    lit("b3_pc", 32'(pc), 32'd2);
    step();
    lit("b3_done_off", 32'(done), 32'd0);

    // Backpressure in first HOLD
    op_ready = 1'b0;
    go(0, 3);
    step();
    for (int i = 0; i < 5; i++) begin
      lit("bp_hold", 32'({op_valid, op_a, op_b}), {15'd0, 1'b1, 16'h000A, 16'h0005} );
      step();
    end
    op_ready = 1'b1;
    step();
    lit("bp_release_v", 32'(op_valid), 32'd0);
    lit("bp_release_pc", 32'(pc), 32'd1);
    drain();

    // Address wrap 15 -> 0
    tbl_a[15] = 16'h1111; tbl_b[15] = 16'h2222;
    go(15, 2);
    step();
    lit("wrap_pc15", 32'(pc), 32'd15);
    lit("wrap_a15", 32'(op_a), 32'h1111);
    lit("wrap_b15", 32'(op_b), 32'h2222);
    step();
    lit("wrap_pc0", 32'(pc), 32'd0);
    step();
    lit("wrap_a0", 32'(op_a), 32'h000A);
    step();
    lit("wrap_done", 32'(done), 32'd1);
    step();

    // Zero-length burst
    go(7, 0);
    lit("zero_done", 32'(done), 32'd1);
    lit("zero_valid", 32'(op_valid), 32'd0);
    lit("zero_pc", 32'(pc), 32'd0);
    step();
    lit("zero_done_off", 32'(done), 32'd0);

    // Abort during HOLD of the second pair, then restart
    go(0, 3);
    step(); step(); step();
    lit("ab_hold2", 32'(op_a), 32'h0010);
    abort = 1'b1;
    step();
    abort = 1'b0;
    lit("ab_flags", 32'({op_valid, busy, done}), 32'd0);
    go(5, 1);
    lit("ab_restart_busy", 32'(busy), 32'd1);
    lit("ab_restart_pc", 32'(pc), 32'd5);
    drain();

    // start while busy is ignored; reset during FETCH clears everything
    op_ready = 1'b0;
    go(0, 2);
    step();
    start = 1'b1; start_addr = 4'd9; count = 5'd4;
    step(); step();
    start = 1'b0;
    lit("busy_start_pc", 32'(pc), 32'd0);
    lit("busy_start_a", 32'(op_a), 32'h000A);
    op_ready = 1'b1;
    step();
    lit("fetch2_pc", 32'(pc), 32'd1);
    rst_n = 1'b0;
    step();
    lit("midrst_pc", 32'(pc), 32'd0);
    lit("midrst_op", 32'({op_a, op_b}), 32'd0);
    lit("midrst_flags", 32'({op_valid, busy, done}), 32'd0);
    rst_n = 1'b1;
    go(3, 1);
    lit("post_rst_busy", 32'(busy), 32'd1);
    lit("post_rst_pc", 32'(pc), 32'd3);
    drain();

    // Randomized soak
    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom % 3) == 0;
      start_addr = ADDR_W'($urandom);
      count      = (($urandom % 8) == 0) ? 5'd0 : (ADDR_W + 1)'($urandom_range(1, 16));
      abort      = ($urandom % 40) == 0;
      op_ready   = ($urandom % 3) != 0;
      rst_n      = ($urandom % 600) != 0;
      if (($urandom % 200) == 0) begin
        tbl_a[$urandom % DEPTH] = DATA_W'($urandom);
      end
      step();
    end
    rst_n = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the operand width.
REQ-002 Parameter ADDR_W, default 4, SHALL set the operand-table address width (16 entries).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-005 start  input  1  SHALL request a burst (sampled in IDLE only).
REQ-006 start_addr  input  ADDR_W  SHALL be the first table address of the burst.
REQ-007 count  input  ADDR_W+1  SHALL be the operand-pair count of the burst (0..16).
REQ-008 abort  input  1  SHALL cancel any burst in progress.
REQ-009 pc  output  ADDR_W  SHALL be the registered address driven to the operand table.
REQ-010 a_in, b_in  input  DATA_W each  SHALL be the combinational table read data for pc.
REQ-011 op_a, op_b  output  DATA_W each  SHALL be the registered operand pair presented downstream.
REQ-012 op_valid  output  1  SHALL indicate op_a/op_b hold a valid pair.
REQ-013 op_ready  input  1  SHALL be the downstream acceptance signal.
REQ-014 busy  output  1  SHALL be high in FETCH and HOLD.
REQ-015 done  output  1  SHALL be a one-cycle pulse on normal burst completion.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, HOLD and DONE.
REQ-017 In IDLE, start=1 with count!=0 SHALL load pc<=start_addr and remaining<=count and go to FETCH.
REQ-018 In IDLE, start=1 with count=0 SHALL go to DONE with no pair issued.
REQ-019 In FETCH (one cycle), op_a<=a_in and op_b<=b_in SHALL be captured and op_valid set to 1 on entry to HOLD.
REQ-020 In HOLD, op_a, op_b and op_valid SHALL remain stable until a cycle with op_ready=1.
REQ-021 A transfer SHALL occur on any clock edge with op_valid=1 and op_ready=1; op_valid SHALL drop on the following cycle.
REQ-022 On a transfer with remaining>1, the FSM SHALL decrement remaining, set pc<=pc+1 (modulo 2^ADDR_W, 15->0 wraps) and return to FETCH.
REQ-023 On a transfer with remaining=1, the FSM SHALL go to DONE without changing pc.
REQ-024 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-025 Latency SHALL be 2 cycles from the start sample to op_valid=1; sustained throughput SHALL be one pair per 2 cycles with op_ready held high.
REQ-026 start while busy or in DONE SHALL be ignored.
REQ-027 abort=1 in FETCH, HOLD or DONE SHALL force IDLE next cycle with op_valid=0, done=0, and no further transfer that cycle.
REQ-028 abort=1 and start=1 together in IDLE: abort SHALL win and the FSM SHALL stay in IDLE.
REQ-029 In IDLE, pc, op_a and op_b SHALL retain their last values; op_valid SHALL be 0.

Reset
REQ-030 When rst_n=0 at a clock edge, state SHALL become IDLE, and pc, remaining, op_a and op_b SHALL become 0.
REQ-031 When rst_n=0 at a clock edge, op_valid, busy and done SHALL become 0.
REQ-032 Reset mid-burst SHALL discard the burst with no done pulse.
REQ-033 The first start SHALL be honoured in the first cycle after rst_n returns high.

Verification
REQ-034 Table[0..2]=(000A,0005),(0010,0008),(00FF,000F); start_addr=0, count=3, op_ready=1 -> pairs issued in that order at cycles 2, 4, 6; done pulses once; final pc=2.
REQ-035 Same table, op_ready low for 5 cycles in the first HOLD -> op_a=000A, op_b=0005 and op_valid held for all 5 cycles; one transfer only once op_ready rises.
REQ-036 Table[15]=(1111,2222), table[0]=(000A,0005); start_addr=15, count=2 -> pc goes 15->0; both pairs issued.
REQ-037 count=0 with start -> done pulses one cycle later; op_valid never asserted; pc unchanged.
REQ-038 abort in HOLD of pair 2 of 3 -> next cycle IDLE, op_valid=0, busy=0, no done pulse; a new start is accepted the cycle after.
REQ-039 rst_n=0 during FETCH, and start asserted while busy, both checked -> all outputs 0 after reset; the busy-time start causes no burst restart.
